// File: rtl/pixel_packer_if.sv
// Pixel-in / chunk-out stream bundle for pixel_packer.
// The slave modport is the packer's view; the master modport drives pixels and sinks beats.
interface pixel_packer_if #(
   parameter int PIXEL_WIDTH      = 16,
   parameter int PIXELS_PER_CHUNK = 8,
   parameter int ADDR_WIDTH       = 27
);
   localparam int LANE_BITS = $clog2(PIXELS_PER_CHUNK);
   localparam int DATA_W    = PIXEL_WIDTH * PIXELS_PER_CHUNK;

   logic                            valid_in;
   logic                            ready_out;
   logic [ADDR_WIDTH-1:0]           addr_in;
   logic [PIXEL_WIDTH-1:0]          data_in;
   logic                            strobe_in;
   logic                            flush_in;
   logic                            valid_out;
   logic                            ready_in;
   logic [ADDR_WIDTH-LANE_BITS-1:0] addr_out;
   logic [DATA_W-1:0]               data_out;
   logic [DATA_W/8-1:0]             strobe_out;
   logic                            last_out;

   modport slave (
      input  valid_in, addr_in, data_in, strobe_in, flush_in, ready_in,
      output ready_out, valid_out, addr_out, data_out, strobe_out, last_out
   );

   modport master (
      output valid_in, addr_in, data_in, strobe_in, flush_in, ready_in,
      input  ready_out, valid_out, addr_out, data_out, strobe_out, last_out
   );
endinterface

// File: rtl/pixel_packer.sv
// Gathers pixel writes into chunk-wide beats with byte strobes; one accumulator, one output register.
// Optional idle auto-flush is enabled by defining PIXEL_PACKER_TIMEOUT_EN.
module pixel_packer #(
   parameter int PIXEL_WIDTH      = 16,
   parameter int PIXELS_PER_CHUNK = 8,
   parameter int ADDR_WIDTH       = 27,
   parameter int TIMEOUT_CYCLES   = 64
) (
   input logic           clk_in,
   input logic           rst_n_in,
   pixel_packer_if.slave pp
);
   localparam int LANE_BITS = $clog2(PIXELS_PER_CHUNK);
   localparam int CHUNK_W   = ADDR_WIDTH - LANE_BITS;
   localparam int DATA_W    = PIXEL_WIDTH * PIXELS_PER_CHUNK;
   localparam int STRB_W    = DATA_W / 8;
   localparam int LANE_SB   = PIXEL_WIDTH / 8;

   if (PIXEL_WIDTH % 8 != 0 || PIXELS_PER_CHUNK < 2 ||
       (PIXELS_PER_CHUNK & (PIXELS_PER_CHUNK - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("pixel_packer: illegal parameter set");
   end

   logic               acc_occ_q,   acc_occ_d;
   logic [CHUNK_W-1:0] acc_chunk_q, acc_chunk_d;
   logic [DATA_W-1:0]  acc_data_q,  acc_data_d;
   logic [STRB_W-1:0]  acc_strb_q,  acc_strb_d;
   logic               flush_pend_q, flush_pend_d;
   logic               valid_out_q, valid_out_d;
   logic [CHUNK_W-1:0] addr_out_q,  addr_out_d;
   logic [DATA_W-1:0]  data_out_q,  data_out_d;
   logic [STRB_W-1:0]  strb_out_q,  strb_out_d;
   logic               last_out_q,  last_out_d;

   logic                 out_free, accept, pix_we, out_load, tmo_fire;
   logic [CHUNK_W-1:0]   in_chunk;
   logic [LANE_BITS-1:0] in_lane;

   assign out_free = !valid_out_q || pp.ready_in;
   assign accept   = pp.valid_in && out_free;
   assign pix_we   = accept && pp.strobe_in;
   assign in_chunk = pp.addr_in[ADDR_WIDTH-1:LANE_BITS];
   assign in_lane  = pp.addr_in[LANE_BITS-1:0];

   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      acc_occ_d    = acc_occ_q;
      acc_chunk_d  = acc_chunk_q;
      acc_data_d   = acc_data_q;
      acc_strb_d   = acc_strb_q;
      flush_pend_d = flush_pend_q || pp.flush_in;
      out_load     = 1'b0;
      addr_out_d   = acc_chunk_q;
      data_out_d   = acc_data_q;
      strb_out_d   = acc_strb_q;
      last_out_d   = 1'b0;

      if (pix_we) begin
         // A pixel for another chunk pushes the current accumulator out before starting fresh.
         if (!acc_occ_q || in_chunk != acc_chunk_q) begin
            out_load   = acc_occ_q;
            acc_data_d = '0;
            acc_strb_d = '0;
         end
         acc_occ_d   = 1'b1;
         acc_chunk_d = in_chunk;
         for (int i = 0; i < PIXELS_PER_CHUNK; i++) begin
            if (LANE_BITS'(i) == in_lane) begin
               acc_data_d[i*PIXEL_WIDTH +: PIXEL_WIDTH] = pp.data_in;
               acc_strb_d[i*LANE_SB +: LANE_SB]         = '1;
            end
         end
         if (&acc_strb_d && !out_load) begin
            out_load   = 1'b1;
            addr_out_d = acc_chunk_d;
            data_out_d = acc_data_d;
            strb_out_d = acc_strb_d;
            acc_occ_d  = 1'b0;
         end
      end

      // Flush acts on the post-merge accumulator; if the slot was just taken it waits a cycle.
      if (flush_pend_d && out_free) begin
         if (!acc_occ_d) begin
            flush_pend_d = 1'b0;
         end else if (!out_load) begin
            out_load     = 1'b1;
            addr_out_d   = acc_chunk_d;
            data_out_d   = acc_data_d;
            strb_out_d   = acc_strb_d;
            last_out_d   = 1'b1;
            acc_occ_d    = 1'b0;
            flush_pend_d = 1'b0;
         end
      end

      if (tmo_fire && !out_load) begin
         out_load  = 1'b1;
         acc_occ_d = 1'b0;
      end

      valid_out_d = out_load || (valid_out_q && !pp.ready_in);
      if (!out_load) begin
         addr_out_d = addr_out_q;
         data_out_d = data_out_q;
         strb_out_d = strb_out_q;
         last_out_d = last_out_q;
      end
   end

`ifdef PIXEL_PACKER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_q, tmo_d;

   assign tmo_fire = acc_occ_q && !accept && out_free && tmo_q == TMO_MAX;

   always_comb begin
      tmo_d = tmo_q;
      if (accept || out_load)              tmo_d = '0;
      else if (acc_occ_q && tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) tmo_q <= '0;
      else           tmo_q <= tmo_d;
   end
`else
   assign tmo_fire = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      // NOTE: state flops take non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n_in) begin
         // NOTE: accumulator payload is reset too, so a partial chunk can never leak after reset.
         acc_occ_q    <= 1'b0;
         acc_chunk_q  <= '0;
         acc_data_q   <= '0;
         acc_strb_q   <= '0;
         flush_pend_q <= 1'b0;
         valid_out_q  <= 1'b0;
         addr_out_q   <= '0;
         data_out_q   <= '0;
         strb_out_q   <= '0;
         last_out_q   <= 1'b0;
      end else begin
         acc_occ_q    <= acc_occ_d;
         acc_chunk_q  <= acc_chunk_d;
         acc_data_q   <= acc_data_d;
         acc_strb_q   <= acc_strb_d;
         flush_pend_q <= flush_pend_d;
         valid_out_q  <= valid_out_d;
         addr_out_q   <= addr_out_d;
         data_out_q   <= data_out_d;
         strb_out_q   <= strb_out_d;
         last_out_q   <= last_out_d;
      end
   end

   assign pp.ready_out  = out_free;
   assign pp.valid_out  = valid_out_q;
   assign pp.addr_out   = addr_out_q;
   assign pp.data_out   = data_out_q;
   assign pp.strobe_out = strb_out_q;
   assign pp.last_out   = last_out_q;
endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer (16-bit pixels, 8 per chunk, timeout 4 when enabled).
module tb_pixel_packer;
   localparam int PW = 16;
   localparam int PPC = 8;
   localparam int AW = 27;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_total = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   pixel_packer_if #(.PIXEL_WIDTH(PW), .PIXELS_PER_CHUNK(PPC), .ADDR_WIDTH(AW)) pif ();

   pixel_packer #(
      .PIXEL_WIDTH(PW), .PIXELS_PER_CHUNK(PPC), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk_in  (clk),
      .rst_n_in(rst_n),
      .pp      (pif)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int a, input logic [15:0] d, input logic st, input logic fl);
      pif.valid_in  = 1'b1;
      pif.addr_in   = AW'(a);
      pif.data_in   = d;
      pif.strobe_in = st;
      pif.flush_in  = fl;
      tick();
      pif.valid_in  = 1'b0;
      pif.strobe_in = 1'b0;
      pif.flush_in  = 1'b0;
   endtask

   task automatic flush_pulse();
      pif.flush_in = 1'b1;
      tick();
      pif.flush_in = 1'b0;
   endtask

   function automatic logic [127:0] put(input logic [127:0] v, input int lane, input logic [15:0] px);
      logic [127:0] r;
      r = v;
      r[lane*16 +: 16] = px;
      return r;
   endfunction

   task automatic check_beat(input string tag, input int a, input logic [15:0] s,
                             input logic [127:0] d, input logic l);
      check({tag, ".valid"}, 128'(pif.valid_out), 128'(1));
      check({tag, ".addr"},  128'(pif.addr_out),  128'(a));
      check({tag, ".strb"},  128'(pif.strobe_out), 128'(s));
      check({tag, ".data"},  pif.data_out, d);
      check({tag, ".last"},  128'(pif.last_out),  128'(l));
   endtask

   initial begin
      logic [127:0] exp_d;
      pif.valid_in = 1'b0; pif.addr_in = '0; pif.data_in = '0;
      pif.strobe_in = 1'b0; pif.flush_in = 1'b0; pif.ready_in = 1'b1;

      #12;
      check("rst.valid", 128'(pif.valid_out), 128'(0));
      check("rst.ready", 128'(pif.ready_out), 128'(1));
      check("rst.data",  pif.data_out, 128'(0));
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Full chunk 0
      exp_d = '0;
      for (int i = 0; i < 8; i++) begin
         check("full.pre_valid", 128'(pif.valid_out), 128'(0));
         send(i, 16'h1000 + 16'(i), 1'b1, 1'b0);
         exp_d = put(exp_d, i, 16'h1000 + 16'(i));
      end
      check_beat("full", 0, 16'hFFFF, exp_d, 1'b0);
      tick();
      check("full.drain", 128'(pif.valid_out), 128'(0));

      // Chunk change displaces partial chunk 2, chunk 5 stays behind
      send(16, 16'h00A0, 1'b1, 1'b0);
      send(18, 16'h00A2, 1'b1, 1'b0);
      check("part.none", 128'(pif.valid_out), 128'(0));
      send(40, 16'h00B0, 1'b1, 1'b0);
      check_beat("part", 2, 16'h0033, put(put('0, 0, 16'h00A0), 2, 16'h00A2), 1'b0);
      flush_pulse();
      check_beat("part.rest", 5, 16'h0003, put('0, 0, 16'h00B0), 1'b1);
      tick();
      check("part.drain", 128'(pif.valid_out), 128'(0));

      // Backpressure holds the beat stable
      pif.ready_in = 1'b0;
      send(24, 16'h00C0, 1'b1, 1'b0);
      flush_pulse();
      check("bp.ready", 128'(pif.ready_out), 128'(0));
      for (int k = 0; k < 10; k++) begin
         check_beat("bp.hold", 3, 16'h0003, put('0, 0, 16'h00C0), 1'b1);
         tick();
      end
      pif.ready_in = 1'b1;
      #1;
      check("bp.ready_rel", 128'(pif.ready_out), 128'(1));
      tick();
      check("bp.drain", 128'(pif.valid_out), 128'(0));

      // Lane overwrite then flush; second flush emits nothing
      send(3, 16'hAAAA, 1'b1, 1'b0);
      send(3, 16'h5555, 1'b1, 1'b0);
      flush_pulse();
      check_beat("ovr", 0, 16'h00C0, put('0, 3, 16'h5555), 1'b1);
      flush_pulse();
      check("ovr.empty_flush", 128'(pif.valid_out), 128'(0));
      tick();
      check("ovr.empty_flush2", 128'(pif.valid_out), 128'(0));

      // Flush coincident with a chunk change: displaced beat first, flushed beat next
      send(8, 16'h0B08, 1'b1, 1'b0);
      send(17, 16'h0B11, 1'b1, 1'b1);
      check_beat("coinc.disp", 1, 16'h0003, put('0, 0, 16'h0B08), 1'b0);
      tick();
      check_beat("coinc.fl", 2, 16'h000C, put('0, 1, 16'h0B11), 1'b1);
      tick();
      check("coinc.drain", 128'(pif.valid_out), 128'(0));

      // Strobe-less pixel is discarded
      send(5, 16'hDEAD, 1'b0, 1'b0);
      flush_pulse();
      check("nostrb.flush", 128'(pif.valid_out), 128'(0));

      // Asynchronous reset with a held beat and a partial chunk
      pif.ready_in = 1'b0;
      send(9, 16'h0909, 1'b1, 1'b0);
      send(16, 16'h1616, 1'b1, 1'b0);
      check("arst.pre_valid", 128'(pif.valid_out), 128'(1));
      check("arst.pre_ready", 128'(pif.ready_out), 128'(0));
      #2 rst_n = 1'b0;
      #1;
      check("arst.valid", 128'(pif.valid_out), 128'(0));
      check("arst.addr",  128'(pif.addr_out), 128'(0));
      check("arst.data",  pif.data_out, 128'(0));
      check("arst.strb",  128'(pif.strobe_out), 128'(0));
      check("arst.last",  128'(pif.last_out), 128'(0));
      check("arst.ready", 128'(pif.ready_out), 128'(1));
      @(negedge clk) rst_n = 1'b1;
      pif.ready_in = 1'b1;
      tick();
      flush_pulse();
      check("arst.flush", 128'(pif.valid_out), 128'(0));
      tick();
      check("arst.flush2", 128'(pif.valid_out), 128'(0));

      // Idle accumulator: auto-flush only when the timeout feature is built in
      send(9, 16'h0999, 1'b1, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         tick();
`ifdef PIXEL_PACKER_TIMEOUT_EN
         check("tmo.valid", 128'(pif.valid_out), 128'(k == 4));
         if (k == 4) check_beat("tmo", 1, 16'h000C, put('0, 1, 16'h0999), 1'b0);
`else
         check("tmo.valid", 128'(pif.valid_out), 128'(0));
`endif
      end
      flush_pulse();
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
